// File: rtl/ifetch.sv
// ifetch: instruction fetch unit.
// Holds the PC, looks up a direct-mapped one-word-per-line instruction cache,
// fetches misses from the memory controller and hands instructions to decode
// under a valid/stall handshake. Execute redirects the PC with jump_flag.
module ifetch #(
    parameter int          ICACHE_IDX_W = 7,
    parameter logic [31:0] RESET_PC     = 32'h0000_0000
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    output logic        if_pc_get,
    output logic [31:0] if_pc_address,
    input  logic        if_done,
    input  logic [31:0] if_out,
    input  logic        jump_flag,
    input  logic [31:0] jump_target,
    input  logic        stall_in,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [31:0] inst_pc
);

    localparam int          LINES      = 1 << ICACHE_IDX_W;
    localparam int          TAG_W      = 16 - ICACHE_IDX_W;
    localparam logic [31:0] PARK_ADDR  = 32'hFFFF_FFFF;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_MISS = 1'b1
    } state_t;

    // Architectural state
    state_t                    r_state;
    logic [31:0]               r_pc;
    logic [31:0]               r_req_addr;
    logic [LINES-1:0]          r_valid;
    logic [TAG_W-1:0]          r_tag  [LINES];
    logic [31:0]               r_data [LINES];

    // Next-state values
    state_t                    w_state_nxt;
    logic [31:0]               w_pc_nxt;
    logic [31:0]               w_req_addr_nxt;
    logic                      w_get_nxt;
    logic [31:0]               w_addr_nxt;
    logic                      w_inst_valid_nxt;
    logic [31:0]               w_inst_nxt;
    logic [31:0]               w_inst_pc_nxt;
    logic                      w_fill;

    // Lookup of the current PC
    logic [ICACHE_IDX_W-1:0]   w_idx;
    logic [TAG_W-1:0]          w_tag;
    logic [ICACHE_IDX_W-1:0]   w_fill_idx;
    logic [TAG_W-1:0]          w_fill_tag;
    logic                      w_hit;
    logic                      w_free;

    assign w_idx      = r_pc[ICACHE_IDX_W+1:2];
    assign w_tag      = r_pc[17:ICACHE_IDX_W+2];
    assign w_fill_idx = r_req_addr[ICACHE_IDX_W+1:2];
    assign w_fill_tag = r_req_addr[17:ICACHE_IDX_W+2];
    assign w_hit      = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
    assign w_free     = !inst_valid || !stall_in;

    // Next-state and output decode; a redirect always wins, an outstanding fill always completes
    always_comb begin
        w_state_nxt      = r_state;
        w_pc_nxt         = r_pc;
        w_req_addr_nxt   = r_req_addr;
        w_get_nxt        = if_pc_get;
        w_addr_nxt       = if_pc_address;
        w_inst_valid_nxt = inst_valid;
        w_inst_nxt       = inst;
        w_inst_pc_nxt    = inst_pc;
        w_fill           = 1'b0;

        // A completing fill parks the address so the controller aborts its spurious restart
        if ((r_state == ST_MISS) && if_done) begin
            w_fill      = 1'b1;
            w_get_nxt   = 1'b0;
            w_addr_nxt  = PARK_ADDR;
            w_state_nxt = ST_IDLE;
        end else begin
            w_fill      = 1'b0;
        end

        if (jump_flag) begin
            w_pc_nxt         = jump_target;
            w_inst_valid_nxt = 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_hit) begin
                        if (w_free) begin
                            w_inst_nxt       = r_data[w_idx];
                            w_inst_pc_nxt    = r_pc;
                            w_inst_valid_nxt = 1'b1;
                            w_pc_nxt         = r_pc + 32'd4;
                        end else begin
                            w_inst_valid_nxt = inst_valid;
                        end
                    end else begin
                        w_get_nxt      = 1'b1;
                        w_addr_nxt     = r_pc;
                        w_req_addr_nxt = r_pc;
                        w_state_nxt    = ST_MISS;
                        if (w_free) begin
                            w_inst_valid_nxt = 1'b0;
                        end else begin
                            w_inst_valid_nxt = inst_valid;
                        end
                    end
                end
                ST_MISS: begin
                    if (if_done && (r_req_addr == r_pc) && w_free) begin
                        w_inst_nxt       = if_out;
                        w_inst_pc_nxt    = r_pc;
                        w_inst_valid_nxt = 1'b1;
                        w_pc_nxt         = r_pc + 32'd4;
                    end else if (w_free) begin
                        w_inst_valid_nxt = 1'b0;
                    end else begin
                        w_inst_valid_nxt = inst_valid;
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    // Control, PC and output registers; everything holds while rdy_in is low
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_state       <= ST_IDLE;
            r_pc          <= RESET_PC;
            r_req_addr    <= 32'h0000_0000;
            if_pc_get     <= 1'b0;
            if_pc_address <= PARK_ADDR;
            inst_valid    <= 1'b0;
            inst          <= 32'h0000_0000;
            inst_pc       <= 32'h0000_0000;
        end else if (rdy_in) begin
            r_state       <= w_state_nxt;
            r_pc          <= w_pc_nxt;
            r_req_addr    <= w_req_addr_nxt;
            if_pc_get     <= w_get_nxt;
            if_pc_address <= w_addr_nxt;
            inst_valid    <= w_inst_valid_nxt;
            inst          <= w_inst_nxt;
            inst_pc       <= w_inst_pc_nxt;
        end
    end

    // Line valid bits; only reset ever invalidates a line
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_valid <= '0;
        end else if (rdy_in && w_fill) begin
            r_valid[w_fill_idx] <= 1'b1;
        end
    end

    // Tag and data arrays, written on fill completion at the requested index
    always_ff @(posedge clk_in) begin
        if (rdy_in && w_fill) begin
            r_tag[w_fill_idx]  <= w_fill_tag;
            r_data[w_fill_idx] <= if_out;
        end
    end

endmodule

// File: tb/tb_ifetch.sv
// Directed bench for ifetch with a latency-6 memory controller model and a
// scoreboard of expected (inst, inst_pc) pairs in issue order.
module tb_ifetch;

    logic        clk_in;
    logic        rst_in;
    logic        rdy_in;
    logic        if_pc_get;
    logic [31:0] if_pc_address;
    logic        if_done;
    logic [31:0] if_out;
    logic        jump_flag;
    logic [31:0] jump_target;
    logic        stall_in;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;

    ifetch dut (
        .clk_in        (clk_in),
        .rst_in        (rst_in),
        .rdy_in        (rdy_in),
        .if_pc_get     (if_pc_get),
        .if_pc_address (if_pc_address),
        .if_done       (if_done),
        .if_out        (if_out),
        .jump_flag     (jump_flag),
        .jump_target   (jump_target),
        .stall_in      (stall_in),
        .inst_valid    (inst_valid),
        .inst          (inst),
        .inst_pc       (inst_pc)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    typedef struct packed {
        logic [31:0] word;
        logic [31:0] pc;
    } exp_t;

    exp_t        sb_q[$];
    int          checks;
    int          errors;
    logic [31:0] last_pc;
    logic        popped;
    logic        m_busy;
    logic [31:0] m_addr;
    int          m_cnt;

    // Memory image: word 0 is a NOP, everything else is derived from its address
    function automatic logic [31:0] mem_word(input logic [31:0] addr);
        if (addr == 32'h0) return 32'h0000_0013;
        return {addr[15:0] ^ 16'h5A5A, addr[15:0]};
    endfunction

    task automatic check32(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic push(input logic [31:0] pc);
        exp_t e;
        e.word = mem_word(pc);
        e.pc   = pc;
        sb_q.push_back(e);
    endtask

    // One clock: monitor newly presented instructions, then step the memory model
    task automatic cycle();
        logic free_b;
        exp_t e;
        logic have;
        free_b = !inst_valid || !stall_in;
        @(posedge clk_in);
        #1;
        popped = 1'b0;
        if (inst_valid === 1'b1 && free_b) begin
            have = (sb_q.size() != 0);
            checks++;
            assert (have) else begin
                errors++;
                $error("FAIL unexpected_issue: got inst_pc %h expected no issue", inst_pc);
            end
            if (have) begin
                e = sb_q.pop_front();
                check32("sb_inst", inst, e.word);
                check32("sb_inst_pc", inst_pc, e.pc);
            end
            last_pc = inst_pc;
            popped  = 1'b1;
        end
        if (if_done) begin
            if_done = 1'b0;
            m_busy  = 1'b0;
        end else if (m_busy) begin
            if (if_pc_address !== m_addr) begin
                m_busy = 1'b0;
            end else begin
                m_cnt++;
                if (m_cnt == 5) begin
                    if_done = 1'b1;
                    if_out  = mem_word(m_addr);
                end
            end
        end
        if (!m_busy && !if_done && if_pc_get === 1'b1) begin
            m_busy = 1'b1;
            m_addr = if_pc_address;
            m_cnt  = 0;
        end
    endtask

    task automatic run_until(input logic [31:0] target);
        logic found;
        found = 1'b0;
        for (int n = 0; n < 60 && !found; n++) begin
            cycle();
            if (popped && last_pc == target) found = 1'b1;
        end
        checks++;
        assert (found) else begin
            errors++;
            $error("FAIL timeout_pc: got last_pc %h expected %h", last_pc, target);
        end
    endtask

    task automatic jump_to(input logic [31:0] t);
        jump_flag   = 1'b1;
        jump_target = t;
        cycle();
        jump_flag   = 1'b0;
    endtask

    initial begin
        logic dropped;
        checks = 0; errors = 0; last_pc = 32'h0; popped = 1'b0;
        m_busy = 1'b0; m_addr = 32'h0; m_cnt = 0;
        rdy_in = 1'b1; if_done = 1'b0; if_out = 32'h0;
        jump_flag = 1'b0; jump_target = 32'h0; stall_in = 1'b0;
        rst_in = 1'b1;
        #12;
        check32("rst_get", {31'd0, if_pc_get}, 32'd0);
        check32("rst_addr", if_pc_address, 32'hFFFF_FFFF);
        check32("rst_valid", {31'd0, inst_valid}, 32'd0);
        check32("rst_inst", inst, 32'h0);
        check32("rst_inst_pc", inst_pc, 32'h0);
        rst_in = 1'b0;

        // Reset fetch and first pass of a 4-word loop
        push(32'h0); push(32'h4); push(32'h8); push(32'hC);
        cycle();
        check32("miss0_get", {31'd0, if_pc_get}, 32'd1);
        check32("miss0_addr", if_pc_address, 32'h0);
        run_until(32'h0);
        check32("fwd0_park", if_pc_address, 32'hFFFF_FFFF);
        check32("fwd0_get", {31'd0, if_pc_get}, 32'd0);
        run_until(32'hC);

        // Second pass is all hits: one instruction per cycle, no fetches
        push(32'h0); push(32'h4); push(32'h8); push(32'hC);
        jump_to(32'h0);
        for (int i = 0; i < 4; i++) begin
            cycle();
            check32("hit_valid", {31'd0, inst_valid}, 32'd1);
            check32("hit_get", {31'd0, if_pc_get}, 32'd0);
        end

        // Stall holds the presented instruction and the PC
        push(32'h0); push(32'h4);
        jump_to(32'h0);
        cycle();
        stall_in = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cycle();
            check32("stall_valid", {31'd0, inst_valid}, 32'd1);
            check32("stall_inst", inst, 32'h0000_0013);
            check32("stall_pc", inst_pc, 32'h0);
        end
        stall_in = 1'b0;
        cycle();
        check32("unstall_pc", inst_pc, 32'h4);

        // Conflict eviction: 0x200 shares index 0 with 0x0
        push(32'h200);
        jump_to(32'h200);
        cycle();
        check32("evict_get", {31'd0, if_pc_get}, 32'd1);
        check32("evict_addr", if_pc_address, 32'h200);
        run_until(32'h200);
        jump_to(32'h0);
        cycle();
        check32("remiss0_get", {31'd0, if_pc_get}, 32'd1);
        check32("remiss0_addr", if_pc_address, 32'h0);
        cycle();
        cycle();

        // Asynchronous reset in the middle of the miss
        #2 rst_in = 1'b1;
        #1;
        check32("arst_get", {31'd0, if_pc_get}, 32'd0);
        check32("arst_addr", if_pc_address, 32'hFFFF_FFFF);
        check32("arst_valid", {31'd0, inst_valid}, 32'd0);
        cycle();
        rst_in = 1'b0;
        cycle();
        check32("post_rst_get", {31'd0, if_pc_get}, 32'd1);
        check32("post_rst_addr", if_pc_address, 32'h0);

        // Redirect while the fetch of 0x8 is outstanding
        push(32'h0); push(32'h4);
        run_until(32'h4);
        cycle();
        check32("miss8_get", {31'd0, if_pc_get}, 32'd1);
        check32("miss8_addr", if_pc_address, 32'h8);
        push(32'h100);
        jump_to(32'h100);
        check32("jmp_get", {31'd0, if_pc_get}, 32'd1);
        check32("jmp_addr", if_pc_address, 32'h8);
        dropped = 1'b0;
        for (int n = 0; n < 20 && !dropped; n++) begin
            cycle();
            if (if_pc_get === 1'b1) check32("jmp_addr_hold", if_pc_address, 32'h8);
            else dropped = 1'b1;
        end
        checks++;
        assert (dropped) else begin
            errors++;
            $error("FAIL timeout_fill8: got if_pc_get %b expected 0", if_pc_get);
        end
        run_until(32'h100);

        // 0x8 was filled despite the redirect, so revisiting it hits
        push(32'h8);
        jump_to(32'h8);
        cycle();
        check32("rehit8_valid", {31'd0, inst_valid}, 32'd1);
        check32("rehit8_get", {31'd0, if_pc_get}, 32'd0);
        check32("rehit8_pc", inst_pc, 32'h8);

        check32("sb_empty", sb_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
